enc_pipe_secded: RTL and testbench

Streaming extended-Hamming (SECDED) encoder with a valid/ready handshake on both sides. It is a pipelined successor to the single-register stage-1 encoder. It computes all parity bits, including the overall even-parity bit, inside the block, and carries the work mode with each word so that modes can be interleaved word by word. It sits between the APB register file and the channel/noise path, and it sustains one codeword per clock under backpressure.

---
 rtl/enc_pipe_secded.sv | 123 ++++++++++++
 tb/tb_enc_pipe_secded.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enc_pipe_secded.sv
// Two-stage streaming SECDED (extended Hamming) encoder with valid/ready on both sides.
// The work mode travels with each word, so consecutive words may use different code sizes.
module enc_pipe_secded #(
  parameter int MAX_CODEWORD_WIDTH = 32,
  parameter int MAX_INFO_WIDTH     = 26,
  parameter int CNT_WIDTH          = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [MAX_INFO_WIDTH-1:0]     data_in,
  input  logic [1:0]                    work_mod,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [MAX_CODEWORD_WIDTH-1:0] data_out,
  output logic [1:0]                    out_mod,
  output logic                          mode_err,
  output logic [CNT_WIDTH-1:0]          word_cnt
);

  // Column code of info bit i: the (i+1)-th integer >= 3 that is not a power of two.
  localparam logic [25:0][4:0] COL_CODE = {
    5'd31, 5'd30, 5'd29, 5'd28, 5'd27, 5'd26, 5'd25, 5'd24, 5'd23, 5'd22, 5'd21,
    5'd20, 5'd19, 5'd18, 5'd17, 5'd15, 5'd14, 5'd13, 5'd12, 5'd11, 5'd10, 5'd9,
    5'd7,  5'd6,  5'd5,  5'd3
  };

  localparam bit MODE2_OK = (MAX_CODEWORD_WIDTH >= 16);
  localparam bit MODE3_OK = (MAX_CODEWORD_WIDTH >= 32);

  logic        v1;
  logic [25:0] d1;
  logic [1:0]  m1;
  logic        v2;

  logic        in_fire;
  logic        out_fire;
  logic        adv2;

  logic        legal;
  logic [25:0] dmask;
  logic [4:0]  syn;
  logic [31:0] cw;

  assign out_valid = v2;
  assign out_fire  = v2 && out_ready;
  assign adv2      = v1 && (!v2 || out_ready);
  assign in_ready  = !v1 || !v2 || out_ready;
  assign in_fire   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1 <= 1'b0;
      d1 <= '0;
      m1 <= '0;
    end else if (in_fire) begin
      v1 <= 1'b1;
      d1 <= 26'(data_in);
      m1 <= work_mod;
    end else if (adv2) begin
      v1 <= 1'b0;
    end
  end

  // Info bits above k are masked off first, so they contribute neither to parity nor to the codeword.
  always_comb begin
    legal = 1'b0;
    dmask = '0;
    syn   = '0;
    cw    = '0;
    case (m1)
      2'b00: begin
        legal = 1'b1;
        dmask = {22'b0, d1[3:0]};
      end
      2'b01: begin
        legal = MODE2_OK;
        dmask = {15'b0, d1[10:0]};
      end
      2'b10: begin
        legal = MODE3_OK;
        dmask = d1;
      end
      default: legal = 1'b0;
    endcase
    for (int i = 0; i < 26; i++) begin
      if (dmask[i[4:0]]) syn = syn ^ COL_CODE[i[4:0]];
    end
    case (m1)
      2'b00:   cw = {24'b0, dmask[3:0], ^{dmask[3:0], syn[2:0]}, syn[2:0]};
      2'b01:   cw = {16'b0, dmask[10:0], ^{dmask[10:0], syn[3:0]}, syn[3:0]};
      2'b10:   cw = {dmask, ^{dmask, syn}, syn};
      default: cw = '0;
    endcase
    if (!legal) cw = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2       <= 1'b0;
      data_out <= '0;
      out_mod  <= '0;
      mode_err <= 1'b0;
    end else if (adv2) begin
      v2       <= 1'b1;
      data_out <= MAX_CODEWORD_WIDTH'(cw);
      out_mod  <= m1;
      mode_err <= !legal;
    end else if (out_fire) begin
      v2 <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_cnt <= '0;
    end else if (out_fire && !mode_err) begin
      word_cnt <= word_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_enc_pipe_secded.sv
// Directed bench for enc_pipe_secded: a scoreboard fed from the spec-level encoder model
// checks every delivered word, plus literal expectations for the documented vectors.
module tb_enc_pipe_secded;

  localparam int CW   = 32;
  localparam int IW   = 26;
  localparam int CNTW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [IW-1:0]   data_in = '0;
  logic [1:0]      work_mod = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [CW-1:0]   data_out;
  logic [1:0]      out_mod;
  logic            mode_err;
  logic [CNTW-1:0] word_cnt;

  enc_pipe_secded #(
    .MAX_CODEWORD_WIDTH(CW),
    .MAX_INFO_WIDTH(IW),
    .CNT_WIDTH(CNTW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .data_in(data_in),
    .work_mod(work_mod),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out(data_out),
    .out_mod(out_mod),
    .mode_err(mode_err),
    .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  m;
    logic        e;
  } exp_t;

  typedef struct {
    int          cyc;
    logic [31:0] d;
  } log_t;

  exp_t q[$];
  log_t lg[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   model_cnt = 0;
  logic        held_valid = 1'b0;
  logic [31:0] held_d;
  logic [1:0]  held_m;
  logic        held_e;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Spec-level encoder: walk integers to find column codes, build the word bit by bit.
  function automatic logic [31:0] model_encode(input logic [25:0] d, input logic [1:0] m,
                                               output logic err);
    int k;
    int p;
    int code;
    logic [31:0] w;
    logic [31:0] par;
    k = 0;
    p = 0;
    err = 1'b0;
    case (m)
      2'd0: begin k = 4;  p = 4; end
      2'd1: begin k = 11; p = 5; end
      2'd2: begin k = 26; p = 6; end
      default: err = 1'b1;
    endcase
    if (!err && (k + p > CW)) err = 1'b1;
    if (err) return 32'h0;
    w = '0;
    par = '0;
    code = 2;
    for (int i = 0; i < k; i++) begin
      code++;
      while ((code & (code - 1)) == 0) code++;
      if (d[i]) par = par ^ 32'(code);
      w[p + i] = d[i];
    end
    for (int j = 0; j < p - 1; j++) w[j] = par[j];
    w[p - 1] = ^w;
    return w;
  endfunction

  // Scoreboard: push on input handshake, pop and compare on output handshake.
  always @(negedge clk) begin
    exp_t e;
    exp_t x;
    if (!rst) begin
      q.delete();
      model_cnt = 0;
      held_valid = 1'b0;
      checkOutput("reset out_valid", 32'(out_valid), 32'h0);
      checkOutput("reset word_cnt", 32'(word_cnt), 32'h0);
      checkOutput("reset data_out", data_out, 32'h0);
      checkOutput("reset in_ready", 32'(in_ready), 32'h1);
    end else begin
      checkOutput("word_cnt", 32'(word_cnt), 32'(model_cnt));
      if (held_valid) begin
        checkOutput("hold out_valid", 32'(out_valid), 32'h1);
        checkOutput("hold data_out", data_out, held_d);
        checkOutput("hold out_mod", 32'(out_mod), 32'(held_m));
        checkOutput("hold mode_err", 32'(mode_err), 32'(held_e));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("[TB] FAIL unexpected word: got 0x%0h, expected none", data_out);
        end else begin
          x = q.pop_front();
          checkOutput("sb data_out", data_out, x.d);
          checkOutput("sb out_mod", 32'(out_mod), 32'(x.m));
          checkOutput("sb mode_err", 32'(mode_err), 32'(x.e));
          if (!x.e) model_cnt = (model_cnt + 1) % (1 << CNTW);
        end
        lg.push_back('{cyc: cyc, d: data_out});
      end
      held_valid = out_valid && !out_ready;
      held_d = data_out;
      held_m = out_mod;
      held_e = mode_err;
      if (in_valid && in_ready) begin
        e.d = model_encode(data_in, work_mod, e.e);
        e.m = work_mod;
        q.push_back(e);
      end
    end
  end

  task automatic applyStimulus(input logic [25:0] d, input logic [1:0] m);
    int n;
    n = 0;
    in_valid = 1'b1;
    data_in = d;
    work_mod = m;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL accept timeout: got in_ready=0, expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitOutput(input string name, input logic [31:0] exp_d, input logic exp_e,
                            input logic [1:0] exp_m);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, " out_valid"}, 32'(out_valid), 32'h1);
    checkOutput({name, " data_out"}, data_out, exp_d);
    checkOutput({name, " mode_err"}, 32'(mode_err), 32'(exp_e));
    checkOutput({name, " out_mod"}, 32'(out_mod), 32'(exp_m));
    @(posedge clk);
    #1;
  endtask

  task automatic checkLastThree(input string name, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] c);
    int s;
    s = lg.size();
    checkOutput({name, " log size ok"}, 32'(s >= 3), 32'h1);
    if (s >= 3) begin
      checkOutput({name, " first"}, lg[s-3].d, a);
      checkOutput({name, " second"}, lg[s-2].d, b);
      checkOutput({name, " third"}, lg[s-1].d, c);
      checkOutput({name, " gap1"}, 32'(lg[s-2].cyc - lg[s-3].cyc), 32'h1);
      checkOutput({name, " gap2"}, 32'(lg[s-1].cyc - lg[s-2].cyc), 32'h1);
    end
  endtask

  initial begin
    logic e;
    logic [25:0] r;

    // Pin the model itself with hand-computed codewords.
    checkOutput("model m1 bit0", model_encode(26'h1, 2'd0, e), 32'h0000001B);
    checkOutput("model m1 ones", model_encode(26'h3FFFFFF, 2'd0, e), 32'h000000FF);
    checkOutput("model m2 ones", model_encode(26'h3FFFFFF, 2'd1, e), 32'h0000FFFF);
    checkOutput("model m3 ones", model_encode(26'h3FFFFFF, 2'd2, e), 32'hFFFFFFFF);
    checkOutput("model m2 bit0", model_encode(26'h1, 2'd1, e), 32'h00000033);
    checkOutput("model m3 bit25", model_encode(26'h2000000, 2'd2, e), 32'h8000001F);
    checkOutput("model illegal", model_encode(26'h3FFFFFF, 2'd3, e), 32'h0);
    checkOutput("model illegal flag", 32'(e), 32'h1);

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    applyStimulus(26'h1, 2'd0);
    waitOutput("m1 bit0", 32'h0000001B, 1'b0, 2'd0);
    checkOutput("m1 bit0 word_cnt", 32'(word_cnt), 32'h1);

    applyStimulus(26'h3FFFFFF, 2'd0);
    applyStimulus(26'h3FFFFFF, 2'd1);
    applyStimulus(26'h3FFFFFF, 2'd2);
    repeat (4) @(negedge clk);
    checkLastThree("all ones", 32'h000000FF, 32'h0000FFFF, 32'hFFFFFFFF);
    @(posedge clk);
    #1;

    applyStimulus(26'h3FFFFFF, 2'd3);
    waitOutput("illegal", 32'h0, 1'b1, 2'd3);
    checkOutput("illegal word_cnt", 32'(word_cnt), 32'h4);

    // Backpressure: two words fill the pipe, the third waits at the input.
    out_ready = 1'b0;
    applyStimulus(26'h1, 2'd0);
    applyStimulus(26'hF, 2'd0);
    in_valid = 1'b1;
    data_in = 26'h7FF;
    work_mod = 2'd1;
    repeat (3) begin
      @(negedge clk);
      #1;
      checkOutput("stall in_ready", 32'(in_ready), 32'h0);
      checkOutput("stall out_valid", 32'(out_valid), 32'h1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    checkLastThree("backpressure", 32'h0000001B, 32'h000000FF, 32'h0000FFFF);
    @(posedge clk);
    #1;
    checkOutput("backpressure word_cnt", 32'(word_cnt), 32'h7);

    // Reset in the middle of a full pipe.
    out_ready = 1'b0;
    applyStimulus(26'h5, 2'd0);
    applyStimulus(26'h6, 2'd1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("midreset out_valid", 32'(out_valid), 32'h0);
    checkOutput("midreset word_cnt", 32'(word_cnt), 32'h0);
    checkOutput("midreset in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checkOutput("post-reset out_valid", 32'(out_valid), 32'h0);
    end
    @(posedge clk);
    #1;

    // Counter wrap over 17 legal random words plus one illegal word.
    for (int i = 0; i < 17; i++) begin
      r = 26'($urandom);
      applyStimulus(r, 2'($urandom_range(0, 2)));
    end
    applyStimulus(26'($urandom), 2'd3);
    repeat (4) @(negedge clk);
    checkOutput("wrap word_cnt", 32'(word_cnt), 32'h1);
    checkOutput("queue drained", 32'(q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
